// File: rtl/mesh_row_reader_if.sv
// rtl/mesh_row_reader_if.sv - row stream handshake between mesh_row_reader and its consumer
interface mesh_row_reader_if #(
  parameter int COLS  = 26,
  parameter int ROW_W = 5
);
  logic [COLS-1:0]  row_data;
  logic [ROW_W-1:0] row_idx;
  logic             row_valid;
  logic             row_ready;
  logic             row_last;

  modport master (
    output row_data,
    output row_idx,
    output row_valid,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_idx,
    input  row_valid,
    input  row_last,
    output row_ready
  );
endinterface

// File: rtl/mesh_row_reader.sv
// rtl/mesh_row_reader.sv - snapshots the pixel mesh on capture and streams it out row by row
module mesh_row_reader #(
  parameter int COLS  = 26,
  parameter int ROWS  = 18,
  parameter int ROW_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COLS*ROWS-1:0] mesh_in,
  input  logic                 capture,
  input  logic                 abort,
  input  logic                 clr_err,
  mesh_row_reader_if.master    row,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [COLS-1:0]  snap [ROWS];
  logic [COLS-1:0]  data_q;
  logic [ROW_W-1:0] idx_q;
  logic [ROW_W-1:0] idx_inc;
  logic             xfer;
  logic             at_last;
  logic             accept;
  logic             ovr_set;

  assign xfer    = (state == S_STREAM) && row.row_ready;
  assign at_last = (idx_q == ROW_W'(ROWS - 1));
  assign idx_inc = idx_q + ROW_W'(1);
  // A new frame can start from IDLE or DONE; a capture during STREAM is an overrun.
  assign accept  = capture && !abort && (state != S_STREAM);
  assign ovr_set = capture && !abort && (state == S_STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (capture) state_nxt = S_STREAM;
        S_STREAM: if (xfer && at_last) state_nxt = S_DONE;
        S_DONE:   state_nxt = capture ? S_STREAM : S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    row.row_valid = 1'b0;
    row.row_last  = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state)
      S_STREAM: begin
        row.row_valid = 1'b1;
        row.row_last  = at_last;
        busy          = 1'b1;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  assign row.row_data = data_q;
  assign row.row_idx  = idx_q;

  // row_data is preloaded from the snapshot so the next row is ready the cycle after a transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) begin
        snap[r] <= '0;
      end
      idx_q  <= '0;
      data_q <= '0;
    end else if (abort) begin
      idx_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      for (int r = 0; r < ROWS; r++) begin
        snap[r] <= mesh_in[r*COLS +: COLS];
      end
      idx_q  <= '0;
      data_q <= mesh_in[COLS-1:0];
    end else if (xfer) begin
      if (at_last) begin
        idx_q  <= '0;
        data_q <= '0;
      end else begin
        idx_q  <= idx_inc;
        data_q <= snap[idx_inc];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (clr_err) begin
      overrun <= 1'b0;
    end
  end

endmodule
